// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory bus bundle: command, address and store data toward the controller,
// load data back to the CPU.
interface mem_bus_ctrl_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-cycle memory bus controller: RAM, an LED output register and a synchronized switch port.
// Optional sticky bus error flag is built only when MEM_BUS_ERR_EN is defined.
module mem_bus_ctrl #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [8:0]  LED_ADDR  = 9'h100,
  parameter logic [8:0]  SW_ADDR   = 9'h140
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_ctrl_if.slave  bus,
  input  logic [7:0]     sw,
  output logic [7:0]     leds,
  output logic           bus_err
);

  localparam int unsigned AddrW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdRsvd  = 2'b11;

  typedef enum logic [1:0] {StIdle = 2'd0, StRd = 2'd1, StWr = 2'd2} state_e;

  state_e      state;
  state_e      state_next;
  logic        rd_en;
  logic        wr_en;
  logic        in_ram;
  logic        in_led;
  logic        in_sw;
  logic [AddrW-1:0] ram_idx;
  logic [15:0] rd_value;
  logic [15:0] read_data;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [15:0] ram [RAM_WORDS];

  // Address decode
  assign in_ram  = ({23'd0, bus.mem_addr} < RAM_WORDS);
  assign in_led  = (bus.mem_addr == LED_ADDR);
  assign in_sw   = (bus.mem_addr == SW_ADDR);
  assign ram_idx = bus.mem_addr[AddrW-1:0];

  // Access FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Access FSM: next state depends only on the command presented this cycle
  always_comb begin
    state_next = state;
    unique case (bus.mem_cmd)
      CmdNone:  state_next = StIdle;
      CmdRead:  state_next = StRd;
      CmdWrite: state_next = StWr;
      CmdRsvd:  state_next = StIdle;
      default:  state_next = StIdle;
    endcase
  end

  // Access FSM: strobes for this edge, suppressed while in reset
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (!reset) begin
      rd_en = (state_next == StRd);
      wr_en = (state_next == StWr);
    end
  end

  always_comb begin
    rd_value = 16'h0000;
    if (in_ram) begin
      rd_value = ram[ram_idx];
    end else if (in_sw) begin
      rd_value = {8'h00, sw_sync};
    end else if (in_led) begin
      rd_value = {8'h00, leds};
    end
  end

  // RAM is never cleared by reset; reads see the pre-write contents
  always_ff @(posedge clk) begin
    if (wr_en && in_ram) begin
      ram[ram_idx] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= 16'h0000;
      leds      <= 8'h00;
      sw_meta   <= 8'h00;
      sw_sync   <= 8'h00;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (rd_en) begin
        read_data <= rd_value;
      end
      if (wr_en && in_led) begin
        leds <= bus.write_data[7:0];
      end
    end
  end

  assign bus.read_data = read_data;

`ifdef MEM_BUS_ERR_EN
  logic err_hit;

  assign err_hit = (bus.mem_cmd == CmdRsvd)
                || ((rd_en || wr_en) && !in_ram && !in_led && !in_sw)
                || (wr_en && in_sw);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (err_hit) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: expected load data is queued when a READ is issued and
// popped after the edge; read_data must hold that value until the next READ.
module tb_mem_bus_ctrl;

  localparam logic [1:0] None  = 2'b00;
  localparam logic [1:0] Read  = 2'b01;
  localparam logic [1:0] Write = 2'b10;
  localparam logic [1:0] Rsvd  = 2'b11;

  localparam logic [15:0] StIdle = 16'd0;
  localparam logic [15:0] StRd   = 16'd1;
  localparam logic [15:0] StWr   = 16'd2;

`ifdef MEM_BUS_ERR_EN
  localparam logic [15:0] ErrExp = 16'd1;
`else
  localparam logic [15:0] ErrExp = 16'd0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] leds;
  logic       bus_err;

  mem_bus_ctrl_if bus_if ();

  mem_bus_ctrl #(
    .RAM_WORDS (256),
    .LED_ADDR  (9'h100),
    .SW_ADDR   (9'h140)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .sw      (sw),
    .leds    (leds),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd_hold = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, sample 1 time unit after the rising edge
  task automatic cycle(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] data);
    @(negedge clk);
    reset               = rst;
    bus_if.mem_cmd      = cmd;
    bus_if.mem_addr     = addr;
    bus_if.write_data   = data;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      rd_hold = 16'h0000;
    end else if (exp_q.size() > 0) begin
      rd_hold = exp_q.pop_front();
    end
    chk("read_data", bus_if.read_data, rd_hold);
  endtask

  task automatic rd(input logic [8:0] addr, input logic [15:0] exp);
    exp_q.push_back(exp);
    cycle(1'b0, Read, addr, 16'h0000);
  endtask

  initial begin
    reset             = 1'b1;
    sw                = 8'h00;
    bus_if.mem_cmd    = None;
    bus_if.mem_addr   = 9'h000;
    bus_if.write_data = 16'h0000;

    cycle(1'b1, None, 9'h000, 16'h0000);
    cycle(1'b1, None, 9'h000, 16'h0000);
    chk("rst_leds", {8'h00, leds}, 16'h0000);
    chk("rst_bus_err", {15'd0, bus_err}, 16'd0);
    chk("rst_state", 16'(dut.state), StIdle);

    // Commands during reset are ignored
    cycle(1'b0, Write, 9'h007, 16'h1234);
    chk("state_wr", 16'(dut.state), StWr);
    cycle(1'b1, Write, 9'h007, 16'hDEAD);
    cycle(1'b1, Write, 9'h100, 16'h00FF);
    chk("leds_in_reset", {8'h00, leds}, 16'h0000);
    chk("state_in_reset", 16'(dut.state), StIdle);
    rd(9'h007, 16'h1234);
    chk("state_rd", 16'(dut.state), StRd);

    // Write then read on consecutive edges
    cycle(1'b0, Write, 9'h005, 16'hBEEF);
    rd(9'h005, 16'hBEEF);

    cycle(1'b0, Write, 9'h100, 16'h12A5);
    chk("leds_write", {8'h00, leds}, 16'h00A5);
    rd(9'h100, 16'h00A5);

    // Hold through idle cycles; reserved command is a no-op
    rd(9'h005, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, None, 9'h005, 16'h0000);
      chk("state_idle", 16'(dut.state), StIdle);
    end
    cycle(1'b0, Rsvd, 9'h005, 16'h0000);
    chk("rsvd_leds", {8'h00, leds}, 16'h00A5);
    chk("rsvd_state", 16'(dut.state), StIdle);
    chk("rsvd_bus_err", {15'd0, bus_err}, ErrExp);
    cycle(1'b0, Rsvd, 9'h100, 16'h0000);
    cycle(1'b0, Write, 9'h1FF, 16'h5555);
    cycle(1'b0, Write, 9'h140, 16'h0077);
    chk("unmapped_wr_leds", {8'h00, leds}, 16'h00A5);
    rd(9'h005, 16'hBEEF);

    // Error and reset on the same edge resolve to clear
    cycle(1'b1, Rsvd, 9'h000, 16'h0000);
    chk("err_rst_bus_err", {15'd0, bus_err}, 16'd0);
    chk("err_rst_leds", {8'h00, leds}, 16'h0000);

    rd(9'h1FF, 16'h0000);
    chk("unmapped_rd_err", {15'd0, bus_err}, ErrExp);
    cycle(1'b0, None, 9'h000, 16'h0000);
    chk("err_sticky", {15'd0, bus_err}, ErrExp);

    // Switch synchronizer: two edges before a change is readable
    sw = 8'h3C;
    rd(9'h140, 16'h0000);
    rd(9'h140, 16'h0000);
    rd(9'h140, 16'h003C);
    sw = 8'h81;
    rd(9'h140, 16'h003C);
    cycle(1'b0, None, 9'h000, 16'h0000);
    rd(9'h140, 16'h0081);

    // Back-to-back traffic and top RAM word
    cycle(1'b0, Write, 9'h010, 16'h1111);
    rd(9'h010, 16'h1111);
    cycle(1'b0, Write, 9'h020, 16'h00AA);
    cycle(1'b0, Write, 9'h021, 16'h00BB);
    rd(9'h020, 16'h00AA);
    rd(9'h021, 16'h00BB);
    cycle(1'b0, Write, 9'h0FF, 16'hCAFE);
    rd(9'h0FF, 16'hCAFE);

    // RAM survives reset, LEDs do not
    cycle(1'b0, Write, 9'h100, 16'h0F33);
    chk("leds_pre_rst", {8'h00, leds}, 16'h0033);
    cycle(1'b1, None, 9'h000, 16'h0000);
    rd(9'h010, 16'h1111);
    chk("leds_post_rst", {8'h00, leds}, 16'h0000);
    chk("bus_err_post_rst", {15'd0, bus_err}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter RAM_WORDS, default 256: RAM depth in 16-bit words; legal values 2..256.
REQ-002 Parameter LED_ADDR, default 9'h100: address of the LED output register.
REQ-003 Parameter SW_ADDR, default 9'h140: address of the switch input port.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_cmd  input  2  CPU memory command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved.
REQ-007 mem_addr  input  9  CPU word address.
REQ-008 write_data  input  16  CPU store data (CPU datapath output).
REQ-009 read_data  output  16  load data returned to the CPU instruction/data input.
REQ-010 sw  input  8  asynchronous slide-switch inputs.
REQ-011 leds  output  8  registered LED drive.
REQ-012 bus_err  output  1  sticky illegal-access flag (see REQ-031).

Function
REQ-013 Address decode: RAM region is mem_addr < RAM_WORDS; LED region is mem_addr == LED_ADDR; SW region is mem_addr == SW_ADDR; all other addresses are unmapped.
REQ-014 RAM write: when mem_cmd == WRITE and the address is in the RAM region, RAM[mem_addr] SHALL take write_data at that edge.
REQ-015 LED write: when mem_cmd == WRITE and mem_addr == LED_ADDR, leds SHALL take write_data[7:0] at that edge; write_data[15:8] is discarded.
REQ-016 Read latency: when mem_cmd == READ at edge N, read_data SHALL present the selected value from edge N onward and hold it until the next READ.
REQ-017 Read sources: RAM[mem_addr]; for SW_ADDR, {8'h00, sw_sync}; for LED_ADDR, {8'h00, leds}; for unmapped addresses, 16'h0000.
REQ-018 A READ of a RAM word returns the contents prior to any write at the same edge; there is no write-through bypass.
REQ-019 NONE, reserved, and unmapped WRITE commands SHALL NOT change RAM, leds, or read_data.
REQ-020 The sw input SHALL pass through a two-flop synchronizer (sw_meta, then sw_sync). A switch change is visible to READ no earlier than 2 edges after it occurs.
REQ-021 Access FSM states:
- IDLE: entered on NONE or reserved.
- RD: entered on READ.
- WR: entered on WRITE.
- The next state is a pure function of the current mem_cmd and is registered.
- The state is exported to no port; the bench probes it hierarchically as an internal signal named state.
REQ-022 Back-to-back commands on consecutive edges SHALL each complete independently, with no stall and no ready signal.
REQ-023 Write-then-read of the same RAM address on consecutive edges SHALL return the newly written data.

Reset
REQ-024 On reset high at an edge:
- read_data = 16'h0000
- leds = 8'h00
- sw_meta = sw_sync = 8'h00
- state = IDLE
- bus_err = 0
REQ-025 While reset is high, mem_cmd SHALL be ignored: no RAM or LED write occurs.
REQ-026 RAM contents SHALL NOT be cleared by reset. Contents after power-up are undefined unless loaded by an initial-file load in synthesis.
REQ-027 If reset asserts mid-sequence, such as on the edge after a WRITE, the RAM write already committed SHALL persist.

Configuration
REQ-028 The macro is MEM_BUS_ERR_EN.
REQ-029 Without MEM_BUS_ERR_EN, bus_err SHALL be tied to 0 and no error logic is built.
REQ-030 With MEM_BUS_ERR_EN, bus_err SHALL set on the edge after any of:
- a READ or WRITE to an unmapped address;
- a WRITE to SW_ADDR;
- mem_cmd == 2'b11.
REQ-031 With MEM_BUS_ERR_EN, bus_err SHALL stay set until reset. A simultaneous error and reset SHALL resolve to 0.

Verification
REQ-032 Reset, then WRITE addr 9'h005 data 16'hBEEF, then READ addr 9'h005 on the next edge -> read_data = 16'hBEEF after that edge.
REQ-033 WRITE addr 9'h100 data 16'h12A5 -> leds = 8'hA5 after the edge; READ 9'h100 -> read_data = 16'h00A5.
REQ-034 sw = 8'h3C, then READ 9'h140 at least 2 edges later -> read_data = 16'h003C; READ 1 edge after a change -> previous value.
REQ-035 READ 9'h005 returns 16'hBEEF, followed by 3 NONE cycles -> read_data held at 16'hBEEF throughout; mem_cmd = 2'b11 -> RAM and leds unchanged.
REQ-036 MEM_BUS_ERR_EN defined: READ 9'h1FF -> read_data = 16'h0000 and bus_err = 1 on the next edge, held until reset clears it. Macro undefined: bus_err stays 0.
REQ-037 WRITE 9'h010 = 16'h1111, then reset for 1 cycle, then READ 9'h010 -> read_data = 16'h1111 and leds = 8'h00.
